// File: rtl/cla_with_dff.sv
// cla_with_dff: two-level carry-lookahead adder with registered outputs.
//
// Computes {Cout, Sum} = A + B + Cin. Inside each 4-bit group the carries are
// flat lookahead sums of products. Each group also produces a group
// propagate/generate pair. A second-level lookahead unit uses those pairs to
// form every group carry-in directly, so no carry ripples from group to group.
// The sum and carry-out are captured in flops on every rising Clk edge.
//
// Build option:
//   CLA_INPUT_REG_EN  When defined, A/B/Cin are first registered. This gives a
//                     2-cycle input-to-output latency instead of 1. The port
//                     list is the same in both builds.
//
// Parameters:
//   WIDTH     operand width; legal values are 4, 8, 12 and 16
// Ports:
//   Clk       clock, rising edge active
//   Reset     synchronous, active-high; clears the outputs (and input regs)
//   A, B      unsigned addends, WIDTH bits
//   Cin       carry-in
//   Sum_out   registered sum, WIDTH bits
//   Cout_out  registered carry-out
module cla_with_dff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Cout_out
);

  localparam int unsigned GROUP = 4;
  localparam int unsigned NG    = WIDTH / GROUP;

  // Reject widths that cannot be split into 1..4 whole groups.
  if ((WIDTH % GROUP) != 0 || NG < 1 || NG > 4) begin : g_bad_width
    $error("cla_with_dff: WIDTH must be 4, 8, 12 or 16");
  end

  // ---------------------------------------------------------------------------
  // Operand source: optional input register stage.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef CLA_INPUT_REG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;

  // Input capture. Reset discards any operand already in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
    end else begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= Cin;
    end
  end

  assign op_a   = a_q;
  assign op_b   = b_q;
  assign op_cin = cin_q;
`else
  assign op_a   = A;
  assign op_b   = B;
  assign op_cin = Cin;
`endif

  // ---------------------------------------------------------------------------
  // Bitwise propagate / generate.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;

  assign p = op_a ^ op_b;
  assign g = op_a & op_b;

  // ---------------------------------------------------------------------------
  // First level: per-group flat lookahead and group P/G.
  // ---------------------------------------------------------------------------
  logic [NG-1:0]    pg;   // group propagate
  logic [NG-1:0]    gg;   // group generate
  logic [NG:0]      cg;   // group carry-ins; cg[NG] is the adder carry-out
  logic [WIDTH-1:0] c;    // per-bit carry-in

  for (genvar j = 0; j < NG; j++) begin : g_grp
    logic p0, p1, p2, p3;
    logic g0, g1, g2, g3;
    logic ci;

    assign p0 = p[GROUP*j + 0];
    assign p1 = p[GROUP*j + 1];
    assign p2 = p[GROUP*j + 2];
    assign p3 = p[GROUP*j + 3];
    assign g0 = g[GROUP*j + 0];
    assign g1 = g[GROUP*j + 1];
    assign g2 = g[GROUP*j + 2];
    assign g3 = g[GROUP*j + 3];
    assign ci = cg[j];

    // Each carry is a two-level AND-OR of the group's G/P and its carry-in.
    assign c[GROUP*j + 0] = ci;
    assign c[GROUP*j + 1] = g0 | (p0 & ci);
    assign c[GROUP*j + 2] = g1 | (p1 & g0) | (p1 & p0 & ci);
    assign c[GROUP*j + 3] = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & ci);

    assign pg[j] = p3 & p2 & p1 & p0;
    assign gg[j] = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0);
  end

  // ---------------------------------------------------------------------------
  // Second level: each group carry-in is an independent flat sum of products
  // over lower groups' GG/PG and the adder carry-in. The loops unroll into
  // a product-term OR; no term reads a previously computed group carry.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic acc;
    logic prod;
    cg    = '0;
    acc   = 1'b0;
    prod  = 1'b0;
    cg[0] = op_cin;
    for (int unsigned j = 1; j <= NG; j++) begin
      acc = 1'b0;
      // Terms where group k generates and groups k+1..j-1 propagate.
      for (int unsigned k = 0; k < j; k++) begin
        prod = gg[k];
        for (int unsigned m = k + 1; m < j; m++) begin
          prod = prod & pg[m];
        end
        acc = acc | prod;
      end
      // Term where the adder carry-in propagates through groups 0..j-1.
      prod = op_cin;
      for (int unsigned m = 0; m < j; m++) begin
        prod = prod & pg[m];
      end
      cg[j] = acc | prod;
    end
  end

  // ---------------------------------------------------------------------------
  // Sum and carry-out.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  assign sum_c  = p ^ c;
  assign cout_c = cg[NG];

  // Output flops. They capture on every edge; Reset takes priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Sum_out  <= '0;
      Cout_out <= 1'b0;
    end else begin
      Sum_out  <= sum_c;
      Cout_out <= cout_c;
    end
  end

endmodule

// File: tb/tb_cla_with_dff.sv
// tb_cla_with_dff: scoreboard bench for cla_with_dff.
// Drives a 4-bit and a 16-bit instance side by side. Each applied cycle
// pushes the expected output into a queue, and a monitor compares the queue
// against both instances after every rising edge.
`timescale 1ns/1ps
module tb_cla_with_dff;

`ifdef CLA_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, cout4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, cout16;

  always #5 Clk = ~Clk;

  cla_with_dff #(.WIDTH(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .A(a4), .B(b4), .Cin(cin4),
    .Sum_out(sum4), .Cout_out(cout4)
  );

  cla_with_dff #(.WIDTH(16)) dut16 (
    .Clk(Clk), .Reset(Reset), .A(a16), .B(b16), .Cin(cin16),
    .Sum_out(sum16), .Cout_out(cout16)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  a4, b4;
    logic        c4;
    logic [15:0] a16, b16;
    logic        c16;
  } stim_t;

  typedef struct {
    int          e;
    logic [4:0]  x4;
    logic [16:0] x16;
  } exp_t;

  stim_t       hist [0:4095];
  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          edge_n = 0;
  logic [4:0]  last4;
  logic [16:0] last16;
  bit          have_last = 0;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  // Applies one cycle of stimulus for the next rising edge. The expected
  // result for that edge follows from the arithmetic A+B+Cin of the inputs
  // applied LAT-1 edges earlier, or zero when a reset falls in that window.
  task automatic apply(input bit rst, input logic [3:0] a_4, input logic [3:0] b_4,
                       input logic c_4, input logic [15:0] a_16, input logic [15:0] b_16,
                       input logic c_16);
    int    e;
    int    src;
    bit    zero;
    exp_t  x;
    e = edge_n + 1;
    Reset = rst; a4 = a_4; b4 = b_4; cin4 = c_4;
    a16 = a_16; b16 = b_16; cin16 = c_16;
    hist[e] = '{rst, a_4, b_4, c_4, a_16, b_16, c_16};
    zero = rst;
    if (LAT == 2) begin
      if (e < 2) zero = 1'b1;
      else if (hist[e-1].rst) zero = 1'b1;
    end
    src = e - LAT + 1;
    x.e = e;
    if (zero) begin
      x.x4  = '0;
      x.x16 = '0;
    end else begin
      x.x4  = 5'(hist[src].a4) + 5'(hist[src].b4) + 5'(hist[src].c4);
      x.x16 = 17'(hist[src].a16) + 17'(hist[src].b16) + 17'(hist[src].c16);
    end
    sbq.push_back(x);
    // Inputs just changed mid-cycle; outputs must still hold the last result.
    #1;
    if (have_last) begin
      check("hold4", {12'b0, cout4, sum4}, {12'b0, last4});
      check("hold16", {cout16, sum16}, last16);
    end
    @(negedge Clk);
  endtask

  task automatic apply_r(input bit rst, input logic [3:0] a_4, input logic [3:0] b_4,
                         input logic c_4);
    apply(rst, a_4, b_4, c_4, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // Monitor: after every rising edge, pops the expectations due for that edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge Clk);
      edge_n = edge_n + 1;
      #1;
      while (sbq.size() > 0 && sbq[0].e <= edge_n) begin
        x = sbq.pop_front();
        if (x.e < edge_n) begin
          check("missed", 17'(x.e), 17'(edge_n));
        end else begin
          check("sum4", {12'b0, cout4, sum4}, {12'b0, x.x4});
          check("sum16", {cout16, sum16}, x.x16);
          last4     = x.x4;
          last16    = x.x16;
          have_last = 1'b1;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [8:0] v;
    // Reset with zero inputs, then with all-ones inputs while still held.
    apply(1, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0);
    apply(1, 4'h0, 4'h0, 0, 16'h0000, 16'h0000, 0);
    apply(1, 4'hF, 4'hF, 0, 16'hFFFF, 16'hFFFF, 0);
    // Directed back-to-back results and carry boundaries.
    apply(0, 4'b1001, 4'b1101, 0, 16'h1234, 16'hEDCB, 1);
    apply(0, 4'b0101, 4'b1010, 0, 16'hFFFF, 16'h0000, 1);
    apply(0, 4'b1101, 4'b1011, 0, 16'hFFFF, 16'hFFFF, 1);
    apply(0, 4'b1111, 4'b0000, 1, 16'h0FFF, 16'h0001, 0);
    apply(0, 4'b1111, 4'b1111, 1, 16'h00FF, 16'hFF00, 1);
    apply(0, 4'b0000, 4'b0000, 0, 16'h0000, 16'h0000, 0);
    apply(0, 4'b1000, 4'b1000, 0, 16'h8000, 16'h8000, 0);
    // Exhaustive 4-bit sweep with random 16-bit operands alongside.
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      apply_r(0, v[3:0], v[7:4], v[8]);
    end
    // One-edge reset in the middle of a stream.
    for (int i = 0; i < 4; i++) apply_r(0, 4'($urandom), 4'($urandom), 1'($urandom));
    apply_r(1, 4'hF, 4'hF, 1);
    for (int i = 0; i < 8; i++) apply_r(0, 4'($urandom), 4'($urandom), 1'($urandom));
    // Drain the scoreboard, bounded by a cycle budget.
    for (int k = 0; k < LAT + 4 && sbq.size() > 0; k++) @(negedge Clk);
    check("drained", 17'(sbq.size()), 17'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
